quick_spi_arbiter: RTL

//  Shares one quick_spi_hard master between NUM_REQ requesters using round-robin arbitration.
//  Per transaction it latches the winner's slave index, operation and outgoing word.
//  It then sequences start_transaction and end_of_transaction on the master.
//  It returns the read byte and a done pulse to the winner only.

---
 rtl/quick_spi_pkg.sv | 20 ++
 rtl/quick_spi_rr_arbiter.sv | 32 +++
 rtl/quick_spi_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/quick_spi_pkg.sv
// Shared encodings and defaults for the quick_spi arbiter slice.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } qspi_state_t;

  localparam logic QSPI_OP_WRITE = 1'b0;
  localparam logic QSPI_OP_READ  = 1'b1;

  localparam int QSPI_TIMEOUT_DEFAULT = 4096;

  // Index width that stays legal for a single requester.
  function automatic int qspi_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quick_spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module quick_spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  logic found;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(k)]) begin
        found               = 1'b1;
        winner[IDX_W'(k)]   = 1'b1;
        winner_idx          = IDX_W'(k);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin sharing of one quick_spi_hard master between NUM_REQ clients.
//   state | meaning
//   IDLE  | waiting for enable and a request; grants on the next edge
//   BUSY  | master running; spi_* frozen until end_of_transaction or watchdog
//   GAP   | one cycle with start low so the master cannot auto-restart
module quick_spi_arbiter
  import quick_spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SLAVE_WIDTH    = 2,
  parameter int OUT_WIDTH      = 16,
  parameter int IN_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = QSPI_TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SLAVE_WIDTH-1:0] req_slave,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*OUT_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [IN_WIDTH-1:0]            rdata,
  output logic                           timeout_err,
  output logic                           spi_enable,
  output logic                           spi_start_transaction,
  output logic [SLAVE_WIDTH-1:0]         spi_slave,
  output logic                           spi_operation,
  output logic [OUT_WIDTH-1:0]           spi_outgoing_data,
  input  logic                           spi_end_of_transaction,
  input  logic [IN_WIDTH-1:0]            spi_incoming_data
);

  localparam int IDX_W = qspi_idx_width(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  qspi_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic [NUM_REQ-1:0]     gnt_d, done_d;
  logic [IN_WIDTH-1:0]    rdata_d;
  logic                   terr_d, en_d, start_d, op_d;
  logic [SLAVE_WIDTH-1:0] slave_d;
  logic [OUT_WIDTH-1:0]   out_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;

  logic [SLAVE_WIDTH-1:0] slave_arr [NUM_REQ];
  logic [OUT_WIDTH-1:0]   wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slave_arr[g] = req_slave[g*SLAVE_WIDTH +: SLAVE_WIDTH];
    assign wdata_arr[g] = req_wdata[g*OUT_WIDTH +: OUT_WIDTH];
  end

  quick_spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wd_d    = wd_q;
    gnt_d   = gnt;
    done_d  = '0;
    rdata_d = rdata;
    terr_d  = 1'b0;
    en_d    = 1'b1;
    start_d = spi_start_transaction;
    slave_d = spi_slave;
    op_d    = spi_operation;
    out_d   = spi_outgoing_data;

    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (enable && any_req) begin
          state_d = ST_BUSY;
          win_d   = pick_idx;
          ptr_d   = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
          gnt_d   = pick_onehot;
          start_d = 1'b1;
          slave_d = slave_arr[pick_idx];
          op_d    = req_op[pick_idx];
          out_d   = wdata_arr[pick_idx];
        end
      end
      ST_BUSY: begin
        // A real completion wins over a watchdog expiry on the same edge.
        if (spi_end_of_transaction) begin
          state_d       = ST_GAP;
          start_d       = 1'b0;
          gnt_d         = '0;
          done_d[win_q] = 1'b1;
          if (spi_operation == QSPI_OP_READ) rdata_d = spi_incoming_data;
        end else if (wd_q == WD_LAST) begin
          state_d       = ST_GAP;
          start_d       = 1'b0;
          en_d          = 1'b0;
          gnt_d         = '0;
          done_d[win_q] = 1'b1;
          terr_d        = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        wd_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= ST_IDLE;
      ptr_q                 <= '0;
      win_q                 <= '0;
      wd_q                  <= '0;
      gnt                   <= '0;
      done                  <= '0;
      rdata                 <= '0;
      timeout_err           <= 1'b0;
      spi_enable            <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_operation         <= 1'b0;
      spi_outgoing_data     <= '0;
    end else begin
      state_q               <= state_d;
      ptr_q                 <= ptr_d;
      win_q                 <= win_d;
      wd_q                  <= wd_d;
      gnt                   <= gnt_d;
      done                  <= done_d;
      rdata                 <= rdata_d;
      timeout_err           <= terr_d;
      spi_enable            <= en_d;
      spi_start_transaction <= start_d;
      spi_slave             <= slave_d;
      spi_operation         <= op_d;
      spi_outgoing_data     <= out_d;
    end
  end

endmodule
